// File: rtl/muldiv_if.sv
// muldiv_if -- request/response bundle between an issuing pipeline and the
// M-extension sequencer.
//
// Handshake: the requester raises start together with funct3/rs1_data/rs2_data
// for one cycle; the op is accepted only when the sequencer is idle (busy=0)
// and flush is low, otherwise the request is dropped (there is no ready, the
// requester watches busy). The sequencer answers with a single-cycle done
// pulse; result is valid in that cycle and holds until the next done.
// flush aborts any op in flight without producing done.
//
// Signals:
//   start, funct3[2:0], rs1_data[31:0], rs2_data[31:0], flush  (requester -> sequencer)
//   busy, done, result[31:0], state_dbg[1:0]                   (sequencer -> requester)
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  busy, done, result, state_dbg
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output busy, done, result, state_dbg
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer -- iterative RV32 M-extension unit (mul/mulh/mulhsu/mulhu,
// div/divu/rem/remu). Operates on magnitudes, one bit per cycle for 32 cycles,
// then applies the sign fix-up and latches the selected result.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   muldiv_if.slave: start/funct3/rs1_data/rs2_data/flush in,
//         busy/done/result/state_dbg out
module muldiv_sequencer (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REMU   = 3'b111;

  state_t      state, state_nxt;
  logic [2:0]  f3_q;
  logic [31:0] opnd_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] acc_q;       // mul: {partial product hi, multiplier}; div: {partial remainder, quotient}
  logic [5:0]  count_q;
  logic        neg_res_q;   // product / quotient sign
  logic        neg_rem_q;   // remainder takes the dividend's sign
  logic [31:0] result_q;

  // Incoming request decode
  logic        accept, in_div, div_zero;
  logic        sgn_a, sgn_b, neg_a, neg_b;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    accept   = (state == IDLE) && bus.start && !bus.flush;
    in_div   = bus.funct3[2];
    sgn_a    = (bus.funct3 != F_MULHU) && (bus.funct3 != F_DIVU) && (bus.funct3 != F_REMU);
    sgn_b    = sgn_a && (bus.funct3 != F_MULHSU);
    neg_a    = sgn_a && bus.rs1_data[31];
    neg_b    = sgn_b && bus.rs2_data[31];
    mag_a    = neg_a ? (32'd0 - bus.rs1_data) : bus.rs1_data;
    mag_b    = neg_b ? (32'd0 - bus.rs2_data) : bus.rs2_data;
    div_zero = in_div && (bus.rs2_data == 32'd0);
  end

  // One iteration step, plus sign fix-up of the post-step value so the final
  // result can be latched on the same edge that leaves CALC.
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_nxt;
  logic [63:0] acc_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fin_result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_nxt   = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // True difference is below the divisor, so 32 bits are exact.
    div_rem   = div_shift[31:0] - opnd_q;
    div_nxt   = div_ge ? {div_rem, acc_q[30:0], 1'b1}
                       : {div_shift[31:0], acc_q[30:0], 1'b0};
    acc_nxt   = f3_q[2] ? div_nxt : mul_nxt;

    prod_fix  = neg_res_q ? (64'd0 - acc_nxt) : acc_nxt;
    quo_fix   = neg_res_q ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
    rem_fix   = neg_rem_q ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];

    case (f3_q)
      F_MUL:                      fin_result = prod_fix[31:0];
      F_MULH, F_MULHSU, F_MULHU:  fin_result = prod_fix[63:32];
      F_DIV, F_DIVU:              fin_result = quo_fix;
      default:                    fin_result = rem_fix;
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_zero ? DONE : CALC;
      CALC:    if (count_q == 6'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q      <= 3'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      count_q   <= 6'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else if (accept) begin
      f3_q      <= bus.funct3;
      count_q   <= 6'd0;
      opnd_q    <= in_div ? mag_b : mag_a;
      acc_q     <= in_div ? {32'd0, mag_a} : {32'd0, mag_b};
      neg_res_q <= neg_a ^ neg_b;
      neg_rem_q <= neg_a;
      // Divide by zero: quotient all ones, remainder is the raw dividend.
      if (div_zero) result_q <= bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
    end else if ((state == CALC) && !bus.flush) begin
      acc_q   <= acc_nxt;
      count_q <= count_q + 6'd1;
      if (count_q == 6'd31) result_q <= fin_result;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result    = result_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   done_cnt;
  logic [31:0] last_res;

  muldiv_if bus ();

  muldiv_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / done-pulse monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  // Reference model: plain 64-bit arithmetic on the operands
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    pu = {32'd0, a} * {32'd0, b};
    r  = 32'd0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: r = pu[63:32];
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in cycle T+1 with junk operands.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    step();
    bus.start    = 1'b0;
    bus.funct3   = 3'($urandom_range(0, 7));
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
  endtask

  // Returns lat = cycles after accept at which done is seen (1 means T+1).
  task automatic wait_done(input bit noise, output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (noise) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.funct3   = 3'($urandom_range(0, 7));
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
      end
      step();
      lat++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    int lat;
    bit busy_ok;
    logic [31:0] exp;
    exp = ref_model(f3, a, b);
    start_op(f3, a, b);
    wait_done(noise, lat, busy_ok);
    chk({tag, " latency"}, 32'(lat), (f3[2] && b == 32'd0) ? 32'd1 : 32'd33);
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " busy_through_op"}, {31'd0, busy_ok}, 32'd1);
    step();
    chk({tag, " idle_after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
    last_res = exp;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Directed + randomized sequence
  initial begin
    int lat, d0;
    bit busy_ok;
    vectors      = 0;
    miscompares  = 0;
    last_res     = 32'd0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.funct3   = 3'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;

    // Reset state, and reset beats a start request
    repeat (2) step();
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_data = 32'd5; bus.rs2_data = 32'd0;
    repeat (2) step();
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    step();

    // Directed examples
    run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu 5/0", 3'd5, 32'd5, 32'd0, 1'b0);
    run_op("remu 5/0", 3'd7, 32'd5, 32'd0, 1'b0);
    run_op("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // divu 7/2, then a start held through DONE: ignored in DONE, taken at T+34
    start_op(3'd5, 32'd7, 32'd2);
    wait_done(1'b0, lat, busy_ok);
    chk("divu 7/2 latency", 32'(lat), 32'd33);
    chk("divu 7/2 result", bus.result, ref_model(3'd5, 32'd7, 32'd2));
    bus.start = 1'b1; bus.funct3 = 3'd7; bus.rs1_data = 32'd7; bus.rs2_data = 32'd2;
    step();
    chk("start in DONE ignored", {31'd0, bus.busy}, 32'd0);
    step();
    chk("start taken at T+34", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done(1'b0, lat, busy_ok);
    chk("remu 7/2 latency", 32'(lat), 32'd33);
    chk("remu 7/2 result", bus.result, ref_model(3'd7, 32'd7, 32'd2));
    last_res = ref_model(3'd7, 32'd7, 32'd2);
    step();

    // flush together with start in IDLE drops the request
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd3; bus.rs2_data = 32'd3;
    step();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush+start dropped", {31'd0, bus.busy}, 32'd0);

    // Flush mid-divide, with a stray start at T+5
    d0 = done_cnt;
    start_op(3'd4, 32'h1234_5678, 32'd77);         // now T+1
    repeat (4) step();                             // T+5
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9;
    step();                                        // T+6
    bus.start = 1'b0;
    chk("stray start no effect", {31'd0, bus.busy}, 32'd1);
    repeat (4) step();                             // T+10
    bus.flush = 1'b1;
    step();                                        // T+11
    bus.flush = 1'b0;
    chk("flush busy", {31'd0, bus.busy}, 32'd0);
    chk("flush done", {31'd0, bus.done}, 32'd0);
    chk("flush keeps result", bus.result, last_res);
    chk("flush no done pulse", 32'(done_cnt - d0), 32'd0);
    run_op("after flush divu", 3'd5, 32'd1000, 32'd7, 1'b0);

    // Reset mid-multiply
    start_op(3'd0, 32'd123, 32'd456);              // now T+1
    repeat (19) step();                            // T+20
    rst = 1'b1;
    step();                                        // T+21
    rst = 1'b0;
    chk("rst mid busy", {31'd0, bus.busy}, 32'd0);
    chk("rst mid done", {31'd0, bus.done}, 32'd0);
    chk("rst mid result", bus.result, 32'd0);
    d0 = done_cnt;
    repeat (40) step();
    chk("rst no later done", 32'(done_cnt - d0), 32'd0);

    // Randomized ops with start noise while busy
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameters SHALL be none; the operand width SHALL be fixed at 32 bits (rv32i_word).
REQ-002 clk  in  1  rising-edge clock; the block SHALL have one clock.
REQ-003 rst  in  1  reset; it SHALL be synchronous and active-high.
REQ-004 start  in  1  request to begin an M-extension op; it SHALL be sampled only in IDLE.
REQ-005 funct3  in  3  muldiv_funct3_t: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-006 rs1_data  in  32  operand A (dividend or multiplicand).
REQ-007 rs2_data  in  32  operand B (divisor or multiplier).
REQ-008 flush  in  1  abort any in-flight op.
REQ-009 busy  out  1  high whenever state != IDLE.
REQ-010 done  out  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  out  32  final value; it SHALL hold until the next done.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013 IDLE->CALC SHALL occur on start&!flush (accept cycle T), latching funct3, magnitudes |A| and |B| per signedness, and the result sign.
REQ-014 Signedness: mul/mulh/div/rem both signed; mulhsu A signed, B unsigned; mulhu/divu/remu both unsigned.
REQ-015 An iteration counter (6 bits) SHALL reset to 0 on accept and increment once per CALC cycle; CALC->DONE SHALL occur when count==31 (32 CALC cycles, T+1..T+32).
REQ-016 Multiply SHALL use shift-add over the 64-bit unsigned magnitude product, one multiplier bit per CALC cycle.
REQ-017 Divide SHALL use restoring division, one quotient bit per CALC cycle, with a 32-bit partial remainder.
REQ-018 Sign fix-up: negate the 64-bit product if signA^signB; negate the quotient if signA^signB; negate the remainder if signA.
REQ-019 Selection: mul = product[31:0]; mulh/mulhsu/mulhu = product[63:32]; div/divu = quotient; rem/remu = remainder.
REQ-020 Divide by zero (div/divu/rem/remu with B==0): IDLE->DONE directly, done at T+1; quotient = 0xFFFFFFFF; remainder = A unmodified.
REQ-021 Overflow (div/rem, A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0; normal 32-cycle latency.
REQ-022 DONE SHALL last one cycle with done=1 and result updated on entry; DONE->IDLE unconditionally; start in DONE SHALL be ignored.
REQ-023 Normal latency: done SHALL be asserted at T+33; the next start SHALL be accepted at T+34 at the earliest.
REQ-024 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-025 flush in any state SHALL force IDLE next cycle, suppress done, and leave result unchanged; flush&start in IDLE SHALL drop the start.
REQ-026 Operand inputs SHALL be ignored after the accept cycle.

Reset
REQ-027 While rst=1: state=IDLE, busy=0, done=0, result=0x00000000, counter=0; rst SHALL take priority over start and flush.
REQ-028 rst mid-CALC SHALL abandon the op; no done SHALL follow; busy=0 the cycle after rst.

Verification
REQ-029 mul 7 x 0xFFFFFFFD (-3), start at T -> done=1 only at T+33, result 0xFFFFFFEB; busy high T+1..T+33.
REQ-030 mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 div 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu 7/2 -> 3; remu -> 1.
REQ-032 divu 5/0 -> 0xFFFFFFFF and remu 5/0 -> 5, each with done at T+1; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0, done at T+33.
REQ-033 div started at T, flush at T+10 -> no done, busy=0 at T+11, result keeps its prior value, new start at T+11 accepted; start pulses at T+5 are ignored.
REQ-034 rst at T+20 of mul -> busy=0, done=0, result=0 at T+21; no done pulse thereafter.
